// File: rtl/flappy_pkg.sv
// Shared Flappy Bird constants and types; color_mapper and pipe logic import the same values.
package flappy_pkg;

  typedef enum logic [1:0] {READY, FLYING, DEAD} bird_state_t;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  localparam logic [9:0] START_Y  = 10'd240;
  localparam logic [9:0] BIRD_X   = 10'd300;
  localparam logic [9:0] BIRD_W   = 10'd40;
  localparam logic [9:0] BIRD_H   = 10'd40;
  localparam logic [9:0] HALF_H   = BIRD_H >> 1;
  localparam logic [9:0] FLOOR_Y  = 10'd400;

  // Legal range of the bird centre row.
  localparam logic [9:0] Y_TOP    = HALF_H;
  localparam logic [9:0] Y_BOTTOM = FLOOR_Y - HALF_H;

  localparam logic signed [5:0] FLAP_VEL = 6'sd8;
  localparam logic signed [5:0] GRAVITY  = 6'sd1;
  localparam logic signed [5:0] MAX_FALL = 6'sd10;

  function automatic logic signed [5:0] fall_vel(input logic signed [5:0] vel);
    logic signed [5:0] v;
    v = vel + GRAVITY;
    return (v > MAX_FALL) ? MAX_FALL : v;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector with synchronous active-high reset.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic sig_q, sig_d;

  always_comb sig_d = sig_in;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_d;
  end

  assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/bird_motion.sv
// Per-frame bird physics, three-state game FSM and combinational hit-box flag.
// state  | meaning
// READY  | parked at START_Y, waiting for the first flap
// FLYING | flap/gravity physics advanced once per frame tick
// DEAD   | falls to the floor ignoring flaps; a flap at the floor restarts
module bird_motion
  import flappy_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       flap,
  input  logic       collide,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] Bird_Y_Pos,
  output logic       is_bird,
  output logic       game_active,
  output logic       game_over
);

  logic frame_tick, flap_rise;

  bird_state_t       state_q, state_d;
  logic [9:0]        y_q, y_d;
  logic signed [5:0] vel_q, vel_d, vel_new;
  logic signed [10:0] y_next;
  logic              flap_pend_q, flap_pend_d;
  logic              game_active_q, game_active_d;
  logic              game_over_q, game_over_d;
  logic              flap_now, at_floor;
  logic [10:0]       dx, dy, yb;

  edge_detect u_frame_edge (
    .clk    (Clk),
    .rst    (Reset),
    .sig_in (frame_clk),
    .rise   (frame_tick)
  );

  edge_detect u_flap_edge (
    .clk    (Clk),
    .rst    (Reset),
    .sig_in (flap),
    .rise   (flap_rise)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= READY;
      y_q           <= START_Y;
      vel_q         <= '0;
      flap_pend_q   <= 1'b0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      y_q           <= y_d;
      vel_q         <= vel_d;
      flap_pend_q   <= flap_pend_d;
      game_active_q <= game_active_d;
      game_over_q   <= game_over_d;
    end
  end

  always_comb begin
    flap_now = flap_pend_q | flap_rise;
    at_floor = (y_q == Y_BOTTOM);
    // DEAD never flaps, so its tick is pure gravity.
    vel_new  = (flap_now && state_q != DEAD) ? -FLAP_VEL : fall_vel(vel_q);
    y_next   = $signed({1'b0, y_q}) + $signed({{5{vel_new[5]}}, vel_new});

    state_d     = state_q;
    y_d         = y_q;
    vel_d       = vel_q;
    flap_pend_d = flap_pend_q | flap_rise;

    case (state_q)
      READY: begin
        y_d   = START_Y;
        vel_d = '0;
        if (frame_tick) begin
          flap_pend_d = 1'b0;
          if (flap_now) begin
            state_d = FLYING;
            vel_d   = vel_new;
            y_d     = y_next[9:0];
          end
        end
      end
      FLYING: begin
        if (collide) begin
          state_d     = DEAD;
          flap_pend_d = 1'b0;
        end else if (frame_tick) begin
          flap_pend_d = 1'b0;
          vel_d       = vel_new;
          y_d         = y_next[9:0];
          if (y_next < $signed({1'b0, Y_TOP})) begin
            y_d   = Y_TOP;
            vel_d = '0;
          end else if (y_next >= $signed({1'b0, Y_BOTTOM})) begin
            y_d     = Y_BOTTOM;
            vel_d   = '0;
            state_d = DEAD;
          end
        end
      end
      DEAD: begin
        flap_pend_d = 1'b0;
        if (at_floor && flap_rise) begin
          state_d = READY;
          y_d     = START_Y;
          vel_d   = '0;
        end else if (frame_tick) begin
          vel_d = vel_new;
          y_d   = y_next[9:0];
          if (y_next < $signed({1'b0, Y_TOP})) begin
            y_d   = Y_TOP;
            vel_d = '0;
          end else if (y_next >= $signed({1'b0, Y_BOTTOM})) begin
            y_d   = Y_BOTTOM;
            vel_d = '0;
          end
        end
      end
      default: begin
        state_d     = READY;
        y_d         = START_Y;
        vel_d       = '0;
        flap_pend_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    game_active_d = (state_d == FLYING);
    game_over_d   = (state_d == DEAD);

    dx = {1'b0, DrawX};
    dy = {1'b0, DrawY};
    yb = {1'b0, y_q};
    is_bird = (dx >= {1'b0, BIRD_X}) && (dx < {1'b0, BIRD_X} + {1'b0, BIRD_W}) &&
              (dy + {1'b0, HALF_H} >= yb) && (dy < yb + {1'b0, HALF_H});
  end

  assign Bird_Y_Pos  = y_q;
  assign game_active = game_active_q;
  assign game_over   = game_over_q;

endmodule
